// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and LSU request ports onto one registered memory port, with one transaction in flight.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration; the default is LSU-over-fetch fixed priority.
module mem_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [DATA_WIDTH-1:0]      i_addr,
  output logic                       i_valid,
  output logic [DATA_WIDTH-1:0]      i_rdata,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [DATA_WIDTH-1:0]      d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wdata,
  input  logic [BYTE_DATA_WIDTH-1:0] d_byte_enable,
  output logic                       d_valid,
  output logic [DATA_WIDTH-1:0]      d_rdata,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [DATA_WIDTH-1:0]      bus_addr,
  output logic [DATA_WIDTH-1:0]      bus_wdata,
  output logic [BYTE_DATA_WIDTH-1:0] bus_byte_enable,
  input  logic                       bus_valid,
  input  logic [DATA_WIDTH-1:0]      bus_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state;
  logic   pick_d;

`ifdef MEM_ARB_RR_EN
  // last_d remembers whether the LSU won the previous grant; reset favours the LSU first.
  logic last_d;

  always_comb pick_d = d_req && (!i_req || !last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_d <= 1'b0;
    else if (state == IDLE && (i_req || d_req))
      last_d <= pick_d;
  end
`else
  always_comb pick_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      bus_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            bus_req <= 1'b1;
            if (pick_d) begin
              state           <= GRANT_D;
              bus_we          <= d_we;
              bus_addr        <= d_addr;
              bus_wdata       <= d_wdata;
              bus_byte_enable <= d_byte_enable;
            end else begin
              state           <= GRANT_I;
              bus_we          <= 1'b0;
              bus_addr        <= i_addr;
              bus_wdata       <= '0;
              bus_byte_enable <= '1;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // Payload stays frozen until memory completes; no preemption.
          if (bus_valid) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is a pass-through of bus_valid so the requester sees it in the same cycle.
  assign i_valid = (state == GRANT_I) && bus_valid;
  assign d_valid = (state == GRANT_D) && bus_valid;
  assign i_rdata = (state == GRANT_I) ? bus_rdata : '0;
  assign d_rdata = (state == GRANT_D) ? bus_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single data-cache/memory port between the instruction fetch path (read-only) and the load/store unit (read/write with byte enables). Sits between the core's request ports and the memory interface. Registers the winning request onto the shared bus, holds it until the memory answers, and routes the response back to the granted requester. One transaction is in flight at a time.

## Interface
- DATA_WIDTH, 32, address and data width
- BYTE_DATA_WIDTH, 4, byte-enable width (DATA_WIDTH/8)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_valid
- i_addr  in  DATA_WIDTH  fetch address
- i_valid  out  1  fetch completion pulse
- i_rdata  out  DATA_WIDTH  fetch read data, valid when i_valid
- d_req  in  1  LSU request; held until d_valid
- d_we  in  1  LSU write enable
- d_addr  in  DATA_WIDTH  LSU address
- d_wdata  in  DATA_WIDTH  LSU write data
- d_byte_enable  in  BYTE_DATA_WIDTH  LSU byte enables
- d_valid  out  1  LSU completion pulse
- d_rdata  out  DATA_WIDTH  LSU read data, valid when d_valid
- bus_req  out  1  shared-port request, registered
- bus_we  out  1  shared-port write enable, registered
- bus_addr  out  DATA_WIDTH  registered address
- bus_wdata  out  DATA_WIDTH  registered write data
- bus_byte_enable  out  BYTE_DATA_WIDTH  registered byte enables
- bus_valid  in  1  memory completion, one cycle per transaction
- bus_rdata  in  DATA_WIDTH  memory read data, valid with bus_valid

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: when any req is high, pick winner (see Configuration), latch its payload into bus_* registers, set bus_req=1, go to GRANT_I/GRANT_D at next edge. No req: stay IDLE, bus_req=0.
- Fetch grant latches bus_we=0, bus_wdata=0, bus_byte_enable=all ones.
- GRANT_x: bus_* held constant. When bus_valid=1: x_valid=bus_valid (combinational), x_rdata=bus_rdata; next edge bus_req=0, state IDLE.
- i_rdata/d_rdata: bus_rdata when the respective port is granted, else 0.
- Non-granted requester sees valid=0; its req stays pending, never dropped.
- bus_valid in IDLE: ignored, no valid pulse generated.
- Requester dropping req mid-grant: illegal; transaction still completes and valid still pulses.
- Requester drops req on the edge after its valid; the IDLE decision therefore sees fresh req levels.

## Timing
- Reset (async): state IDLE; bus_req, bus_we=0; bus_addr, bus_wdata, bus_byte_enable=0; i_valid, d_valid=0; i_rdata, d_rdata=0; last-grant register=fetch.
- Reset mid-transaction: in-flight transaction abandoned; later bus_valid ignored.
- Latency: req seen in IDLE cycle 0 -> bus_req high cycle 1 -> bus_valid in cycle k>=1 -> requester valid in cycle k -> IDLE in cycle k+1.
- Zero-wait memory (bus_valid in first bus_req cycle): 2 cycles per access, sustained.
- Decision made only in IDLE; no preemption of a granted transaction.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. Both requesting in IDLE -> grant the port not granted last; single requester always wins. Last-grant register updates at each grant.
- MEM_ARB_RR_EN undefined: fixed priority, LSU (d) over fetch (i); last-grant register not implemented.

## Test plan
- Fetch only: i_req=1, i_addr=0x100, bus_valid after 3 wait cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_we=0, bus_byte_enable=4'hF; i_valid one cycle, i_rdata=0xDEADBEEF; d_valid=0.
- LSU write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_byte_enable=4'b0011, zero-wait memory -> bus_* carry those values from cycle 1, d_valid in cycle 1, bus_req=0 in cycle 2.
- Simultaneous i_req/d_req, fixed priority -> LSU granted first, fetch second; round-robin build, both held for 4 accesses -> grants alternate d, i, d, i from reset.
- Payload stability: change d_addr 0x200->0x300 during wait states -> bus_addr stays 0x200 until completion.
- Reset mid-transaction: assert rst in cycle 2 of a 4-wait-cycle fetch -> all outputs 0 immediately; post-reset bus_valid with no req -> no i_valid/d_valid.
- Stray bus_valid in IDLE -> i_valid=d_valid=0, state remains IDLE.
